// File: rtl/pr_bus_arbiter_if.sv
// rtl/pr_bus_arbiter_if.sv - CPU, DMA and bridge-side signal bundle for pr_bus_arbiter
interface pr_bus_arbiter_if;
    logic [29:0] cpu_addr;
    logic        cpu_we;
    logic        cpu_re;
    logic [31:0] cpu_wd;
    logic [31:0] cpu_rd;
    logic        cpu_stall;

    logic        dma_req;
    logic        dma_we;
    logic [29:0] dma_addr;
    logic [31:0] dma_wd;
    logic        dma_ack;
    logic [31:0] dma_rd;
    logic        dma_err;

    logic [29:0] bus_addr;
    logic        bus_we;
    logic [31:0] bus_wd;
    logic [31:0] bus_rd;
    logic        owner;

    // The arbiter itself.
    modport slave (
        input  cpu_addr, cpu_we, cpu_re, cpu_wd,
        output cpu_rd, cpu_stall,
        input  dma_req, dma_we, dma_addr, dma_wd,
        output dma_ack, dma_rd, dma_err,
        output bus_addr, bus_we, bus_wd,
        input  bus_rd,
        output owner
    );

    // The surrounding CPU, DMA engine and bridge.
    modport master (
        output cpu_addr, cpu_we, cpu_re, cpu_wd,
        input  cpu_rd, cpu_stall,
        output dma_req, dma_we, dma_addr, dma_wd,
        input  dma_ack, dma_rd, dma_err,
        input  bus_addr, bus_we, bus_wd,
        output bus_rd,
        input  owner
    );
endinterface

// File: rtl/pr_bus_arbiter.sv
// rtl/pr_bus_arbiter.sv - CPU-priority peripheral bus arbiter with DMA cycle stealing and starvation-forced slots; ARB_DMA_ERR_EN enables the DMA address window check
module pr_bus_arbiter #(
    parameter int unsigned STARVE_MAX = 16,
    parameter logic [31:0] DMA_LO     = 32'h0000_7F00,
    parameter logic [31:0] DMA_HI     = 32'h0000_7F2C
) (
    input  logic clk,
    input  logic reset,
    pr_bus_arbiter_if.slave arb
);

`ifdef ARB_DMA_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FORCE = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  count_q, count_d;
    logic [31:0] dma_rd_q, dma_rd_d;
    logic        dma_err_q, dma_err_d;

    logic        cpu_acc;
    logic        grant;
    logic        stall;
    logic [31:0] dma_byte_addr;
    logic        dma_addr_bad;

    assign cpu_acc       = arb.cpu_re | arb.cpu_we;
    assign dma_byte_addr = {arb.dma_addr, 2'b00};
    // Constant-folds to 0 when the window check is compiled out.
    assign dma_addr_bad  = ERR_EN && ((dma_byte_addr < DMA_LO) || (dma_byte_addr > DMA_HI));

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        dma_rd_d  = dma_rd_q;
        dma_err_d = dma_err_q;
        grant     = 1'b0;
        stall     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!arb.dma_req) begin
                    count_d = 8'd0;
                end else if (!cpu_acc) begin
                    grant   = 1'b1;
                    count_d = 8'd0;
                    state_d = ST_ACK;
                end else begin
                    count_d = count_q + 8'd1;
                    if (count_d == 8'(STARVE_MAX)) begin
                        state_d = ST_FORCE;
                    end
                end
            end
            ST_FORCE: begin
                count_d = 8'd0;
                // A request withdrawn before its slot is ignored; no stall is
                // requested for a transfer that will not happen.
                if (arb.dma_req) begin
                    grant   = 1'b1;
                    stall   = 1'b1;
                    state_d = ST_ACK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACK: begin
                count_d = 8'd0;
                state_d = ST_IDLE;
            end
            default: begin
                count_d = 8'd0;
                state_d = ST_IDLE;
            end
        endcase

        if (grant) begin
            if (dma_addr_bad) begin
                dma_rd_d  = 32'd0;
                dma_err_d = 1'b1;
            end else begin
                dma_err_d = 1'b0;
                if (!arb.dma_we) begin
                    dma_rd_d = arb.bus_rd;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            count_q   <= 8'd0;
            dma_rd_q  <= 32'd0;
            dma_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            dma_rd_q  <= dma_rd_d;
            dma_err_q <= dma_err_d;
        end
    end

    // An out-of-window DMA address never reaches the bridge: address zeroed
    // and the write strobe dropped.
    assign arb.bus_addr  = grant ? (dma_addr_bad ? 30'd0 : arb.dma_addr) : arb.cpu_addr;
    assign arb.bus_we    = grant ? (arb.dma_we & ~dma_addr_bad) : arb.cpu_we;
    assign arb.bus_wd    = grant ? arb.dma_wd : arb.cpu_wd;
    assign arb.owner     = grant;
    assign arb.cpu_rd    = arb.bus_rd;
    assign arb.cpu_stall = stall;
    assign arb.dma_ack   = (state_q == ST_ACK);
    assign arb.dma_rd    = dma_rd_q;
    assign arb.dma_err   = (state_q == ST_ACK) & dma_err_q;

endmodule

// File: doc/pr_bus_arbiter.md
Name: pr_bus_arbiter

Overview:
Shares the single peripheral bus (bridge side of the CPU's PrAddr/PrWE/PrWD/PrRD) between the CPU and a second master (DMA/loader). The CPU has priority and is never delayed in normal operation; the DMA steals cycles in which the CPU is not accessing the bus. A starvation counter forces one DMA slot by requesting a one-cycle CPU stall, which the hazard unit consumes. It sits between CPU and bridge; device reads are combinational (same-cycle data).

Parameters:
STARVE_MAX, 16, consecutive denied DMA cycles before a forced slot (2..255)
DMA_LO, 32'h0000_7F00, lowest byte address the DMA may touch (ARB_DMA_ERR_EN only)
DMA_HI, 32'h0000_7F2C, highest byte address the DMA may touch (ARB_DMA_ERR_EN only)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
cpu_addr  in  30  CPU word address [31:2]
cpu_we  in  1  CPU write (already masked by IntReq)
cpu_re  in  1  CPU load in M stage
cpu_wd  in  32  CPU write data
cpu_rd  out  32  read data to CPU (= bus_rd)
cpu_stall  out  1  stall request to hazard unit
dma_req  in  1  DMA request, held until dma_ack
dma_we  in  1  DMA write (1) / read (0)
dma_addr  in  30  DMA word address [31:2]
dma_wd  in  32  DMA write data
dma_ack  out  1  one-cycle completion pulse
dma_rd  out  32  registered DMA read data, valid with dma_ack
dma_err  out  1  error flag with dma_ack (0 unless ARB_DMA_ERR_EN)
bus_addr  out  30  to bridge
bus_we  out  1  to bridge
bus_wd  out  32  to bridge
bus_rd  in  32  from bridge, combinational
owner  out  1  0 = CPU drives the bus, 1 = DMA drives it

Behaviour:
- cpu_acc = cpu_re | cpu_we. States: IDLE, FORCE, ACK. Reset: state IDLE, starve count 0, dma_ack 0, dma_rd 0, dma_err 0, cpu_stall 0.
- IDLE, dma_req=0: owner 0, bus = CPU signals, count 0.
- IDLE, dma_req=1, cpu_acc=0: DMA wins this cycle. owner 1, bus driven by the DMA signals, count cleared. At the clock edge dma_rd <= bus_rd (reads only; writes leave dma_rd unchanged), then go to ACK.
- IDLE, dma_req=1, cpu_acc=1: CPU keeps the bus and count increments. When the incremented count equals STARVE_MAX, go to FORCE.
- FORCE: cpu_stall=1 combinationally. owner 1 regardless of cpu_acc, and the CPU write is suppressed (bus_we = dma_we). DMA access completes as in the DMA-win case, then go to ACK with count cleared. The hazard unit must hold the CPU M stage so the CPU access is retried next cycle.
- ACK: dma_ack=1 for exactly one cycle. No DMA grant this cycle, so owner 0 and the CPU is served; dma_req is not sampled. Next state is IDLE.
- Minimum DMA transfer spacing is therefore 2 cycles; back-to-back requests are allowed by holding dma_req through ACK.
- Forced stall latency: at most STARVE_MAX+1 cycles from dma_req to the DMA access.
- The CPU sees zero-latency access; cpu_rd = bus_rd always (don't-care when owner=1).
- dma_req dropping before ack is illegal; the block ignores the request from that cycle on and clears count.
- Asynchronous reset mid-FORCE or mid-ACK: state returns to IDLE immediately, no ack issued, cpu_stall deasserts immediately.

Optional Feature:
ARB_DMA_ERR_EN: when defined, a DMA byte address ({dma_addr,2'b00}) outside [DMA_LO,DMA_HI] is never placed on the bus. In a granted cycle bus_we is forced to 0, and dma_ack in ACK comes with dma_err=1 and dma_rd=0. Grant, starvation and ack timing are unchanged. When undefined, all DMA addresses pass through and dma_err is tied 0.

Test Plan:
- Reset with dma_req=1, cpu_re=1 -> all outputs 0, owner 0. After release the count starts from 0.
- cpu_acc=0, DMA read addr 0x7F04>>2, bus_rd=32'hDEADBEEF -> owner=1 that cycle, dma_ack=1 next cycle with dma_rd=32'hDEADBEEF, then IDLE.
- cpu_acc held 1 with dma_req=1, STARVE_MAX=16 -> cpu_stall=1 exactly on cycle 16, DMA write 32'h12345678 on bus with cpu_we suppressed, dma_ack on cycle 17.
- CPU idle on alternate cycles with dma_req held -> DMA transfers every 2 cycles, ACK cycles always owner 0, cpu_stall never asserted.
- Reset asserted during FORCE -> cpu_stall drops same cycle, no dma_ack.
- ARB_DMA_ERR_EN, DMA write to byte address 0x0000_0000 -> bus_we=0, dma_ack=1 with dma_err=1.
